// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : load-use / branch / memory-wait hazard and stall controller
// Rev 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1Addr_id,
  input  logic [4:0]       rs2Addr_id,
  input  logic             rs1Used_id,
  input  logic             rs2Used_id,
  input  logic             Jump_id,
  input  logic [4:0]       rdAddr_ex,
  input  logic             MemRead_ex,
  input  logic             BranchTaken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_IFWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             Pipe_Freeze,
  output logic             MEMWB_Bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [0:0]  RUN      = 1'b0;
  localparam logic [0:0]  MWAIT    = 1'b1;
  localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT);

  logic             mem_stall_w;
  logic             load_use_w;
  logic             lu_active_w;
  logic [0:0]       state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  assign mem_stall_w = dmem_req & ~dmem_ready;
  assign load_use_w  = MemRead_ex & (rdAddr_ex != 5'd0) &
                       ((rs1Used_id & (rs1Addr_id == rdAddr_ex)) |
                        (rs2Used_id & (rs2Addr_id == rdAddr_ex)));
  assign lu_active_w = ~mem_stall_w & ~BranchTaken_ex & load_use_w;

  always_comb begin
    PC_IFWrite   = 1'b1;
    IFID_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    Pipe_Freeze  = 1'b0;
    MEMWB_Bubble = 1'b0;
    if (reset) begin
      PC_IFWrite   = 1'b0;
      IFID_Write   = 1'b0;
      IFID_Flush   = 1'b1;
      IDEX_Flush   = 1'b1;
      MEMWB_Bubble = 1'b1;
    end else if (mem_stall_w) begin
      // Frozen stages re-present any branch/jump/load-use once memory is ready.
      PC_IFWrite   = 1'b0;
      IFID_Write   = 1'b0;
      Pipe_Freeze  = 1'b1;
      MEMWB_Bubble = 1'b1;
    end else if (BranchTaken_ex) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (load_use_w) begin
      PC_IFWrite = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end else if (Jump_id) begin
      IFID_Flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = mem_stall_w ? MWAIT : RUN;
    wait_cnt_d = 16'd0;
    if (mem_stall_w) begin
      if (state_q == MWAIT)
        wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
      else
        wait_cnt_d = 16'd1;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if (mem_stall_w && (state_q == MWAIT) && (({1'b0, wait_cnt_q} + 17'd1) >= TO_LIMIT))
      timeout_d = 1'b1;
    if (mem_stall_w && (state_q == RUN) && (TO_LIMIT <= 17'd1))
      timeout_d = 1'b1;
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if ((mem_stall_w | lu_active_w) && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + 1'b1;
    if (IFID_Flush && (flush_q != {CNT_W{1'b1}}))
      flush_d = flush_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_hazard_ctrl : scoreboard bench with directed and random hazard traffic
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;

  localparam int CW = 4;
  localparam int TO = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       jmp;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    logic [5:0]    ctrl;
    logic          to;
    logic [CW-1:0] st;
    logic [CW-1:0] fl;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs1Addr_id = '0, rs2Addr_id = '0, rdAddr_ex = '0;
  logic rs1Used_id = 0, rs2Used_id = 0, Jump_id = 0, MemRead_ex = 0;
  logic BranchTaken_ex = 0, dmem_req = 0, dmem_ready = 0;
  logic PC_IFWrite, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze, MEMWB_Bubble;
  logic mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
    .Jump_id(Jump_id), .rdAddr_ex(rdAddr_ex), .MemRead_ex(MemRead_ex),
    .BranchTaken_ex(BranchTaken_ex), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_IFWrite(PC_IFWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .Pipe_Freeze(Pipe_Freeze), .MEMWB_Bubble(MEMWB_Bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state: event totals and current run of stalled cycles.
  int m_stall = 0, m_flush = 0, m_run = 0;
  bit m_to = 0;

  function automatic logic [5:0] ctrl_of(input stim_t s);
    bit ms, lu;
    ms = s.req && !s.rdy;
    lu = s.mr && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    // order: PC_IFWrite IFID_Write IFID_Flush IDEX_Flush Pipe_Freeze MEMWB_Bubble
    if (s.rst)     return 6'b001101;
    else if (ms)   return 6'b000011;
    else if (s.br) return 6'b111100;
    else if (lu)   return 6'b000100;
    else if (s.jmp) return 6'b111000;
    else           return 6'b110000;
  endfunction

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    logic [5:0] c;
    @(posedge clk);
    #1;
    reset = s.rst; rs1Addr_id = s.rs1; rs2Addr_id = s.rs2;
    rs1Used_id = s.u1; rs2Used_id = s.u2; Jump_id = s.jmp;
    rdAddr_ex = s.rd; MemRead_ex = s.mr; BranchTaken_ex = s.br;
    dmem_req = s.req; dmem_ready = s.rdy;
    c = ctrl_of(s);
    if (s.rst) begin
      m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
    end
    e.ctrl = c;
    e.to   = m_to;
    e.st   = CW'(m_stall);
    e.fl   = CW'(m_flush);
    expq.push_back(e);
    if (!s.rst) begin
      if (c == 6'b000011 || c == 6'b000100) m_stall = sat(m_stall);
      if (c[3]) m_flush = sat(m_flush);
      m_run = (c == 6'b000011) ? m_run + 1 : 0;
      if (m_run >= TO) m_to = 1;
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      n_cmp += 4;
      if ({PC_IFWrite, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze, MEMWB_Bubble} !== e.ctrl) begin
        n_err++;
        $display("FAIL ctrl t=%0t got=%b want=%b", $time,
                 {PC_IFWrite, IFID_Write, IFID_Flush, IDEX_Flush, Pipe_Freeze, MEMWB_Bubble}, e.ctrl);
      end
      if (mem_timeout !== e.to) begin
        n_err++;
        $display("FAIL mem_timeout t=%0t got=%b want=%b", $time, mem_timeout, e.to);
      end
      if (stall_cycles !== e.st) begin
        n_err++;
        $display("FAIL stall_cycles t=%0t got=%0d want=%0d", $time, stall_cycles, e.st);
      end
      if (flush_events !== e.fl) begin
        n_err++;
        $display("FAIL flush_events t=%0t got=%0d want=%0d", $time, flush_events, e.fl);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1;
    repeat (2) apply(s);
    // load-use on rs1, then a clean cycle
    s = idle(); s.mr = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
    apply(s);
    apply(idle());
    // x0 destination and unused rs2 never stall
    s = idle(); s.mr = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
    apply(s);
    s = idle(); s.mr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 0;
    apply(s);
    // branch beats load-use
    s = idle(); s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 1; s.br = 1;
    apply(s);
    apply(idle());
    // jump alone, then jump with load-use
    s = idle(); s.jmp = 1;
    apply(s);
    s.mr = 1; s.rd = 3; s.rs1 = 3; s.u1 = 1;
    apply(s);
    // 3-cycle memory wait with branch held high, branch flushes on ready
    s = idle(); s.req = 1; s.br = 1;
    repeat (3) apply(s);
    s.rdy = 1;
    apply(s);
    apply(idle());
    // load-use followed by a memory wait
    s = idle(); s.mr = 1; s.rd = 9; s.rs1 = 9; s.u1 = 1;
    apply(s);
    s = idle(); s.req = 1;
    repeat (2) apply(s);
    s.rdy = 1;
    apply(s);
    // timeout: 6 stall cycles, flag sticks past ready
    s = idle(); s.rst = 1;
    apply(s);
    s = idle(); s.req = 1;
    repeat (6) apply(s);
    s.rdy = 1;
    apply(s);
    repeat (3) apply(idle());
    // reset while waiting on memory
    s = idle(); s.req = 1;
    repeat (2) apply(s);
    s.rst = 1;
    apply(s);
    s.rst = 0;
    apply(s);
    s.rdy = 1;
    apply(s);
    // saturation: 20 stall cycles
    s = idle(); s.rst = 1;
    apply(s);
    s = idle(); s.req = 1;
    repeat (20) apply(s);
    s.rdy = 1;
    apply(s);
    // random traffic with small register space to force collisions
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 39) == 0);
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.u1  = 1'($urandom);
      s.u2  = 1'($urandom);
      s.mr  = 1'($urandom);
      s.jmp = ($urandom_range(0, 3) == 0);
      s.br  = ($urandom_range(0, 4) == 0);
      s.req = 1'($urandom);
      s.rdy = ($urandom_range(0, 2) == 0);
      apply(s);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left=%0d want=0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It sits beside the decode stage and combines three inputs: decoded register usage in ID, load and branch status in EX, and the data-memory handshake in MEM. From these it drives the PC, IF/ID, ID/EX and MEM/WB write-enable, flush and freeze controls. It also tracks multi-cycle memory waits with a small FSM, flags hung memory accesses and keeps saturating stall and flush counters for performance debug.

## Interface
- CNT_W, 32, width of the performance counters
- TIMEOUT, 256, consecutive memory-stall cycles before `mem_timeout` is set (1..65535)
- clk  input  1  core clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- rs1Addr_id  input  5  rs1 field of the instruction in ID
- rs2Addr_id  input  5  rs2 field of the instruction in ID
- rs1Used_id  input  1  the ID instruction reads rs1
- rs2Used_id  input  1  the ID instruction reads rs2
- Jump_id  input  1  JAL/JALR decoded in ID (target computed in ID)
- rdAddr_ex  input  5  destination register of the EX instruction
- MemRead_ex  input  1  the EX instruction is a load
- BranchTaken_ex  input  1  branch resolved taken in EX
- dmem_req  input  1  the MEM-stage instruction is accessing data memory
- dmem_ready  input  1  data memory completes the access this cycle
- PC_IFWrite  output  1  PC update enable
- IFID_Write  output  1  IF/ID register write enable
- IFID_Flush  output  1  clear IF/ID to a NOP
- IDEX_Flush  output  1  clear ID/EX to a bubble (all control bits 0)
- Pipe_Freeze  output  1  hold PC, IF/ID, ID/EX and EX/MEM
- MEMWB_Bubble  output  1  write a bubble into MEM/WB
- mem_timeout  output  1  sticky flag: memory stall exceeded TIMEOUT
- stall_cycles  output  CNT_W  count of stall cycles
- flush_events  output  CNT_W  count of flush cycles

## Operation
- Derived terms:
  - `mem_stall = dmem_req & ~dmem_ready`
  - `load_use = MemRead_ex & (rdAddr_ex != 0) & ((rs1Used_id & rs1Addr_id == rdAddr_ex) | (rs2Used_id & rs2Addr_id == rdAddr_ex))`
- Per-cycle priority, highest first:
  1. **mem_stall**:
     - `Pipe_Freeze=1`, `MEMWB_Bubble=1`, `PC_IFWrite=0`, `IFID_Write=0`.
     - All flushes are 0; any branch, jump or load-use is deferred, because the frozen stages re-present it.
  2. **BranchTaken_ex**:
     - `IFID_Flush=1`, `IDEX_Flush=1`, `PC_IFWrite=1` (redirect).
     - load_use and Jump_id are ignored, because both instructions are squashed.
  3. **load_use**:
     - `PC_IFWrite=0`, `IFID_Write=0`, `IDEX_Flush=1`.
     - A simultaneous Jump_id is not flushed this cycle; it re-asserts next cycle.
  4. **Jump_id**: `IFID_Flush=1`, `PC_IFWrite=1`.
  5. **Otherwise**: `PC_IFWrite=1`, `IFID_Write=1`, all other controls 0.
- FSM, states RUN and MWAIT:
  - RUN → MWAIT when mem_stall.
  - MWAIT stays while mem_stall and increments a 16-bit `wait_cnt`.
  - MWAIT → RUN on the first cycle without mem_stall; `wait_cnt` clears to 0.
  - The FSM only tracks the wait and drives timeout detection; outputs follow the priority list above.
- mem_timeout:
  - Set at the clock edge that ends the TIMEOUT-th consecutive mem_stall cycle.
  - Cleared only by reset.
  - The freeze continues regardless of the flag.
- stall_cycles: +1 on every cycle with mem_stall or an active load_use (priority 3).
- flush_events: +1 on every cycle with `IFID_Flush=1` outside reset.
- Both counters saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the current inputs, with zero latency; they must settle within the same cycle they steer.
- State, `wait_cnt`, `mem_timeout` and both counters update on the clk rising edge; counter values are visible the cycle after the counted event.
- While reset is high:
  - State = RUN, `wait_cnt` = 0, `mem_timeout` = 0, counters = 0.
  - `PC_IFWrite=0`, `IFID_Write=0`, `IFID_Flush=1`, `IDEX_Flush=1`, `Pipe_Freeze=0`, `MEMWB_Bubble=1`.
- Reset asserted mid-MWAIT returns to RUN immediately (asynchronous) and discards the partial wait count.
- A load-use stall lasts exactly 1 cycle, since the load moves to MEM.
- A load-use followed by a memory wait extends the stall by the wait length; IDEX_Flush is not repeated during the freeze.
- A register read of x0 never triggers load_use.

## Test plan
- **Load-use on rs1**: load x5 in EX (`MemRead_ex=1`, `rdAddr_ex=5`), ID reads `rs1=5` → exactly 1 cycle with `PC_IFWrite=0`, `IFID_Write=0`, `IDEX_Flush=1`; `stall_cycles` goes 0→1.
- **x0 and unused operands**: `rdAddr_ex=0`, or `rs2Addr_id=5` with `rs2Used_id=0` → no stall, `PC_IFWrite=1`.
- **Branch vs load-use**: `BranchTaken_ex=1` together with a load_use condition → `IFID_Flush=1`, `IDEX_Flush=1`, `PC_IFWrite=1`; `flush_events` +1, `stall_cycles` unchanged.
- **Memory wait**: `dmem_req=1` with `dmem_ready` low for 3 cycles, then high → `Pipe_Freeze=1` and `MEMWB_Bubble=1` for 3 cycles, the FSM returns to RUN on the ready cycle, `stall_cycles` +3; a `BranchTaken_ex` held high during the wait flushes only on the ready cycle.
- **Timeout**: TIMEOUT=4, `dmem_ready` held low for 6 cycles → `mem_timeout` rises after the 4th stall cycle and stays 1 after ready, until reset.
- **Reset and saturation**: assert reset while in MWAIT → reset output values appear immediately, state is RUN on release; with CNT_W=4 and 20 stall cycles, `stall_cycles` holds at 15.
